// File: rtl/alu_result_disp.sv
// ALU result display: keeps the last four ALU results and shows the selected one
// on three 7-segment digits plus carry/overflow LEDs, with browse and overflow blink.
module alu_result_disp #(
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_valid,
    input  logic [3:0] res,
    input  logic       car,
    input  logic       of,
    input  logic [2:0] ctrl,
    input  logic       hold,
    input  logic       browse,
    output logic [7:0] seg_res,
    output logic [7:0] seg_sign,
    output logic [7:0] seg_idx,
    output logic [1:0] led
);

    localparam int unsigned   CNT_W     = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
    localparam logic [7:0]    SEG_DASH  = 8'hBF;
    localparam logic [7:0]    SEG_BLANK = 8'hFF;
    localparam logic [2:0]    HIST_FULL = 3'd4;

    typedef struct packed {
        logic [2:0] ctrl;
        logic       of;
        logic       car;
        logic [3:0] res;
    } entry_t;

    function automatic logic [7:0] glyph(input logic [3:0] v);
        logic [7:0] g;
        g = SEG_BLANK;
        case (v)
            4'h0: g = 8'hC0;
            4'h1: g = 8'hF9;
            4'h2: g = 8'hA4;
            4'h3: g = 8'hB0;
            4'h4: g = 8'h99;
            4'h5: g = 8'h92;
            4'h6: g = 8'h82;
            4'h7: g = 8'hF8;
            4'h8: g = 8'h80;
            4'h9: g = 8'h90;
            4'hA: g = 8'h88;
            4'hB: g = 8'h83;
            4'hC: g = 8'hC6;
            4'hD: g = 8'hA1;
            4'hE: g = 8'h86;
            4'hF: g = 8'h8E;
        endcase
        return g;
    endfunction

    entry_t           hist [4];
    logic [1:0]       wr_ptr;
    logic [2:0]       count;
    logic [1:0]       view;
    logic [1:0]       view_nxt;
    logic [2:0]       view_step;
    logic             browse_q;
    logic             browse_rise;
    logic             capture;
    logic [CNT_W-1:0] blink_cnt;
    logic             phase;

    logic [1:0]       rd_idx;
    entry_t           disp;
    logic [3:0]       mag;
    logic [7:0]       seg_res_nxt;
    logic [7:0]       seg_sign_nxt;
    logic [7:0]       seg_idx_nxt;
    logic [1:0]       led_nxt;

    assign capture     = res_valid & ~hold;
    assign browse_rise = browse & ~browse_q;

    // History storage needs no reset; an empty buffer is masked by count.
    always_ff @(posedge clk) begin
        if (capture) begin
            hist[wr_ptr] <= {ctrl, of, car, res};
        end
    end

    // A capture always returns the view to the newest entry, swallowing any browse edge.
    always_comb begin
        view_step = {1'b0, view} + 3'd1;
        view_nxt  = view;
        if (capture) begin
            view_nxt = 2'd0;
        end else if (browse_rise && (count != 3'd0)) begin
            view_nxt = (view_step >= count) ? 2'd0 : view_step[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= 2'd0;
            count     <= 3'd0;
            view      <= 2'd0;
            browse_q  <= 1'b0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            browse_q <= browse;
            view     <= view_nxt;
            if (capture) begin
                wr_ptr <= wr_ptr + 2'd1;
                if (count != HIST_FULL) begin
                    count <= count + 3'd1;
                end
            end
            if (blink_cnt == CNT_MAX) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + CNT_W'(1);
            end
        end
    end

    assign rd_idx = wr_ptr - 2'd1 - view;
    assign disp   = hist[rd_idx];
    assign mag    = disp.res[3] ? (~disp.res + 4'd1) : disp.res;

    // Digit decode of the selected entry; add/sub results are shown signed.
    always_comb begin
        seg_res_nxt  = SEG_DASH;
        seg_sign_nxt = SEG_BLANK;
        seg_idx_nxt  = SEG_DASH;
        led_nxt      = 2'b00;
        if (count != 3'd0) begin
            if (disp.ctrl == 3'b000 || disp.ctrl == 3'b001) begin
                seg_res_nxt  = glyph(mag);
                seg_sign_nxt = disp.res[3] ? SEG_DASH : SEG_BLANK;
            end else begin
                seg_res_nxt  = glyph(disp.res);
            end
            if (disp.of && phase) begin
                seg_res_nxt = SEG_BLANK;
            end
            seg_idx_nxt = glyph({2'b00, view});
            led_nxt     = {disp.of, disp.car};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_res  <= SEG_DASH;
            seg_sign <= SEG_BLANK;
            seg_idx  <= SEG_DASH;
            led      <= 2'b00;
        end else begin
            seg_res  <= seg_res_nxt;
            seg_sign <= seg_sign_nxt;
            seg_idx  <= seg_idx_nxt;
            led      <= led_nxt;
        end
    end

endmodule

// File: tb/tb_alu_result_disp.sv
// Bench for alu_result_disp: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked every cycle against a queue-based display model.
module tb_alu_result_disp;

    localparam int BDIV = 4;
    localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                         8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    localparam logic [25:0] RST_OUT = {8'hBF, 8'hFF, 8'hBF, 2'b00};

    logic       clk;
    logic       rst_n;
    logic       res_valid;
    logic [3:0] res;
    logic       car;
    logic       of;
    logic [2:0] ctrl;
    logic       hold;
    logic       browse;
    logic [7:0] seg_res;
    logic [7:0] seg_sign;
    logic [7:0] seg_idx;
    logic [1:0] led;

    int checks   = 0;
    int failures = 0;

    alu_result_disp #(.BLINK_DIV(BDIV)) dut (
        .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res(res), .car(car), .of(of),
        .ctrl(ctrl), .hold(hold), .browse(browse), .seg_res(seg_res), .seg_sign(seg_sign),
        .seg_idx(seg_idx), .led(led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [25:0] act, input logic [25:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: history as a newest-first list, view as a list index.
    logic [8:0]  mq [$];
    int          mview;
    int          mk;
    logic        mprev;
    logic [25:0] mexp;
    logic        mon_en;

    function automatic logic [25:0] model_disp();
        logic [8:0] e;
        logic [7:0] sr;
        logic [7:0] ss;
        int v;
        if (mq.size() == 0) return RST_OUT;
        e  = mq[mview];
        ss = 8'hFF;
        if (e[8:6] <= 3'd1) begin
            v  = (e[3:0] >= 4'd8) ? int'(e[3:0]) - 16 : int'(e[3:0]);
            sr = GLYPH[(v < 0) ? -v : v];
            if (v < 0) ss = 8'hBF;
        end else begin
            sr = GLYPH[e[3:0]];
        end
        if (e[5] && ((mk / BDIV) % 2 == 1)) sr = 8'hFF;
        return {sr, ss, GLYPH[mview], e[5], e[4]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mview = 0;
            mk    = 0;
            mprev = 1'b0;
            mexp  = RST_OUT;
        end else begin
            mexp = model_disp();
            if (res_valid && !hold) begin
                mq.push_front({ctrl, of, car, res});
                if (mq.size() > 4) void'(mq.pop_back());
                mview = 0;
            end else if (browse && !mprev && mq.size() > 0) begin
                mview = (mview + 1) % mq.size();
            end
            mprev = browse;
            mk++;
        end
    end

    always @(posedge clk) begin
        if (mon_en) begin
            #1;
            chk("monitor", {seg_res, seg_sign, seg_idx, led}, mexp);
        end
    end

    typedef struct packed {
        logic       rv;
        logic [3:0] res;
        logic       car;
        logic       of;
        logic [2:0] ctrl;
        logic       hold;
        logic       browse;
        logic [7:0] e_res;
        logic [7:0] e_sign;
        logic [7:0] e_idx;
        logic [1:0] e_led;
    } vec_t;

    vec_t tbl [17];

    task automatic drive(input logic rv, input logic [3:0] r, input logic c, input logic o,
                         input logic [2:0] op, input logic h, input logic b);
        @(negedge clk);
        res_valid = rv; res = r; car = c; of = o; ctrl = op; hold = h; browse = b;
        @(negedge clk);
        res_valid = 1'b0; hold = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [7:0] sr, input logic [7:0] ss,
                              input logic [7:0] si, input logic [1:0] l);
        chk(name, {seg_res, seg_sign, seg_idx, led}, {sr, ss, si, l});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; res_valid = 1'b0; hold = 1'b0; browse = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic browse_edge();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        drive(1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    logic [7:0] bs [16];
    logic [7:0] exp_res [5];
    logic [7:0] exp_idx [5];
    int         ch;

    initial begin
        rst_n = 1'b0; res_valid = 1'b0; res = 4'h0; car = 1'b0; of = 1'b0;
        ctrl = 3'd0; hold = 1'b0; browse = 1'b0; mon_en = 1'b0;

        //          rv  res  car of ctrl  hold brw  seg_res seg_sign seg_idx led
        tbl[0]  = '{1'b1, 4'h5, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h92, 8'hFF, 8'hC0, 2'b00};
        tbl[1]  = '{1'b1, 4'hD, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 8'hB0, 8'hBF, 8'hC0, 2'b01};
        tbl[2]  = '{1'b1, 4'hD, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 8'hA1, 8'hFF, 8'hC0, 2'b00};
        tbl[3]  = '{1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'hB0, 8'hBF, 8'hF9, 2'b01};
        tbl[4]  = '{1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'hB0, 8'hBF, 8'hF9, 2'b01};
        tbl[5]  = '{1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'h92, 8'hFF, 8'hA4, 2'b00};
        tbl[6]  = '{1'b1, 4'h7, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 8'h92, 8'hFF, 8'hA4, 2'b00};
        tbl[7]  = '{1'b1, 4'h8, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'h80, 8'hBF, 8'hC0, 2'b00};
        tbl[8]  = '{1'b1, 4'hA, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 8'h88, 8'hFF, 8'hC0, 2'b01};
        tbl[9]  = '{1'b1, 4'hF, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 8'h8E, 8'hFF, 8'hC0, 2'b00};
        tbl[10] = '{1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'h88, 8'hFF, 8'hF9, 2'b01};
        tbl[11] = '{1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h88, 8'hFF, 8'hF9, 2'b01};
        tbl[12] = '{1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'h80, 8'hBF, 8'hA4, 2'b00};
        tbl[13] = '{1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h80, 8'hBF, 8'hA4, 2'b00};
        tbl[14] = '{1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'hA1, 8'hFF, 8'hB0, 2'b00};
        tbl[15] = '{1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'hA1, 8'hFF, 8'hB0, 2'b00};
        tbl[16] = '{1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'h8E, 8'hFF, 8'hC0, 2'b00};

        repeat (2) @(posedge clk);
        #1;
        expect_out("reset_state", 8'hBF, 8'hFF, 8'hBF, 2'b00);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rv, tbl[i].res, tbl[i].car, tbl[i].of, tbl[i].ctrl, tbl[i].hold,
                  tbl[i].browse);
            expect_out($sformatf("vec%0d", i), tbl[i].e_res, tbl[i].e_sign, tbl[i].e_idx,
                       tbl[i].e_led);
        end

        // Five captures then a full browse lap over a full buffer.
        do_reset();
        for (int i = 1; i <= 5; i++) drive(1'b1, 4'(i), 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
        exp_res = '{8'h92, 8'h99, 8'hB0, 8'hA4, 8'h92};
        exp_idx = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'hC0};
        expect_out("lap0", exp_res[0], 8'hFF, exp_idx[0], 2'b00);
        for (int i = 1; i < 5; i++) begin
            browse_edge();
            expect_out($sformatf("lap%0d", i), exp_res[i], 8'hFF, exp_idx[i], 2'b00);
        end

        // Overflow blink with a half-period of BDIV cycles.
        do_reset();
        drive(1'b1, 4'h6, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
        chk("blink_led", {24'd0, led}, {24'd0, 2'b10});
        bs[0] = seg_res;
        for (int i = 1; i < 16; i++) begin
            @(posedge clk);
            #1;
            bs[i] = seg_res;
        end
        ch = 0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("blink_glyph%0d", i), {25'd0, (bs[i] == 8'h82 || bs[i] == 8'hFF)}, 26'd1);
            if (i > 0 && bs[i] != bs[i-1]) ch++;
            if (i < 12) chk($sformatf("blink_period%0d", i), {25'd0, bs[i] != bs[i+4]}, 26'd1);
        end
        chk("blink_changes", {25'd0, (ch >= 3 && ch <= 4)}, 26'd1);

        // Short mid-cycle reset pulse after three captures.
        do_reset();
        for (int i = 1; i <= 3; i++) drive(1'b1, 4'(i), 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
        expect_out("pre_pulse", 8'hB0, 8'hFF, 8'hC0, 2'b00);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("rst_pulse", 8'hBF, 8'hFF, 8'hBF, 2'b00);
        #1;
        rst_n = 1'b1;
        browse_edge();
        expect_out("post_pulse_browse", 8'hBF, 8'hFF, 8'hBF, 2'b00);

        // Randomized traffic, checked every cycle by the monitor.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            res_valid = ($urandom_range(0, 9) < 3);
            hold      = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 2) == 0) browse = ~browse;
            res  = 4'($urandom_range(0, 15));
            car  = 1'($urandom_range(0, 1));
            of   = ($urandom_range(0, 3) == 0);
            ctrl = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
        res_valid = 1'b0; hold = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
